reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the bit width of the shared D-flip-flop register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge triggered.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits: level write request, bit i from requester i.
REQ-006 The block SHALL have port wdata, input, NREQ*WIDTH bits: requester i data on bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port gnt, output, NREQ bits: registered one-hot grant.
REQ-008 The block SHALL have port Q, output, WIDTH bits: shared register contents.
REQ-009 The block SHALL have port q_valid, output, 1 bit: one-cycle pulse in the cycle after Q updates.
REQ-010 The block SHALL have port owner, output, clog2(NREQ) bits: index of the last granted requester.
REQ-011 The block SHALL have port wr_count, output, 8 bits: saturating count of completed writes.

Function
REQ-012 The controller SHALL be a two-state machine, IDLE and GRANT.
REQ-013 In IDLE with req nonzero, at the next edge the block SHALL set gnt to the one-hot winner, set owner to the winner, and enter GRANT.
REQ-014 The winner SHALL be the first set req bit searching upward from pointer ptr, wrapping from NREQ-1 to 0.
REQ-015 In IDLE with req zero, the block SHALL stay in IDLE with gnt zero.
REQ-016 In GRANT, at the next edge the block SHALL load Q with the owner's wdata slice, clear gnt, and set ptr to owner+1 mod NREQ.
REQ-016a In the same GRANT exit edge, the block SHALL increment wr_count saturating at 255 and return to IDLE.
REQ-017 q_valid SHALL be high exactly in the cycle after the GRANT exit edge.
REQ-018 wdata SHALL be sampled only at the GRANT exit edge; wdata changes during IDLE SHALL have no effect.
REQ-019 A granted write SHALL complete even if the owner drops req during GRANT.
REQ-020 A requester still asserting req after its write SHALL be treated as a new request, ranked by the updated ptr.
REQ-021 Minimum spacing between writes SHALL be 2 cycles (IDLE -> GRANT -> IDLE), so each write takes one GRANT cycle and one IDLE cycle.
REQ-022 gnt SHALL never have more than one bit set; gnt SHALL be nonzero only in GRANT.
REQ-023 Q SHALL hold its value in all cycles other than the GRANT exit edge.

Reset
REQ-024 On rst_n low, regardless of the clock, the block SHALL force the following: state IDLE, gnt 0, Q 0, q_valid 0, owner 0, ptr 0, wr_count 0.
REQ-025 Reset asserted during GRANT SHALL abort the write, leaving Q at 0 and wr_count unchanged from its reset value 0.
REQ-026 After rst_n deasserts, the first arbitration SHALL occur at the first rising clk edge at which rst_n is high.

Verification
REQ-027 Reset check: rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-028 Single requester: req=0001, wdata slice0=8'hA5 -> gnt=0001 one cycle later, Q=A5 the next cycle, q_valid pulses once, wr_count=1.
REQ-029 Fairness: req=1111 held constant with slices 11,22,33,44 -> grants in order 0,1,2,3,0, each 2 cycles apart, and Q follows 11,22,33,44,11.
REQ-030 Wrap and skip: after owner=3, req=1010 -> gnt=0010; next gnt=1000; next gnt=0010.
REQ-031 Drop during GRANT: req=0100 with wdata=5A, req released in GRANT -> Q=5A, wr_count incremented, no second grant.
REQ-032 Saturation and reset: 260 writes -> wr_count=255; then rst_n low during GRANT -> Q=0, wr_count=0, gnt=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter that lets NREQ requesters take turns writing one shared
// WIDTH-bit register. Each write takes one GRANT cycle followed by one IDLE
// cycle; data is sampled from the owner's slice on the GRANT exit edge.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req       - level write request, bit i from requester i
//   wdata     - requester i data on [i*WIDTH +: WIDTH]
//   gnt       - registered one-hot grant (nonzero only in GRANT)
//   Q         - shared register contents
//   q_valid   - one-cycle pulse in the cycle after Q updates
//   owner     - index of the last granted requester
//   wr_count  - saturating count of completed writes
module reg_write_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      Q,
    output logic                  q_valid,
    output logic [IdxW-1:0]       owner,
    output logic [7:0]            wr_count
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [7:0]        wr_count_q, wr_count_d;

    logic              found_hi, found_lo;
    logic [IdxW-1:0]   win_hi, win_lo, winner;
    logic [WIDTH-1:0]  owner_data;
    logic [IdxW-1:0]   ptr_next;

    // Rotating priority: lowest requester at or above ptr wins; otherwise the
    // search wraps and the lowest requester overall wins.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found_hi && req[i] && (IdxW'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                win_hi   = IdxW'(i);
            end
            if (!found_lo && req[i]) begin
                found_lo = 1'b1;
                win_lo   = IdxW'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    // Owner's data slice, selected without a variable part-select.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (owner_q == IdxW'(i)) begin
                owner_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + IdxW'(1);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        q_d        = q_q;
        q_valid_d  = 1'b0;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        wr_count_d = wr_count_q;
        unique case (state_q)
            StIdle: begin
                gnt_d = '0;
                if (|req) begin
                    for (int i = 0; i < int'(NREQ); i++) begin
                        gnt_d[i] = (winner == IdxW'(i));
                    end
                    owner_d = winner;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // The write completes even if the owner has dropped req.
                q_d        = owner_data;
                gnt_d      = '0;
                ptr_d      = ptr_next;
                q_valid_d  = 1'b1;
                wr_count_d = (wr_count_q == 8'hFF) ? 8'hFF : wr_count_q + 8'd1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign gnt      = gnt_q;
    assign Q        = q_q;
    assign q_valid  = q_valid_q;
    assign owner    = owner_q;
    assign wr_count = wr_count_q;

endmodule
